core_sequencer: RTL and testbench

- Multi-cycle control FSM for the core. Drives the 3-bit `state` bus consumed by the decoder and the other datapath stages: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4, plus FAULT=5.
- Sequences instruction-memory, data-memory, FPU and I/O handshakes.
- Emits single-cycle write enables for the IR, PC, integer register file and FP register file.
- Counts retired instructions.

---
 rtl/core_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WRITE with handshake sequencing,
// single-cycle write-enable pulses, a retired-instruction counter and a sticky timeout FAULT.
module core_sequencer #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             fpu_done,
    input  logic             rx_valid,
    input  logic             tx_ready,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             use_fpu,
    input  logic             data_in,
    input  logic             data_out,
    input  logic             reg_write,
    input  logic             writef,
    output logic [2:0]       state,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             fpu_start,
    output logic             rx_ready,
    output logic             tx_valid,
    output logic             pc_we,
    output logic             rf_we,
    output logic             fpr_we,
    output logic [CNT_W-1:0] retired,
    output logic             fault
);

    localparam int unsigned WAIT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WRITE  = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    state_e             state_q;
    logic               imem_req_q, ir_we_q, dmem_req_q, dmem_we_q;
    logic               pc_we_q, rf_we_q, fpr_we_q, fault_q, first_q;
    logic [CNT_W-1:0]   retired_q;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               l_mr_q, l_mw_q, l_fpu_q, l_din_q, l_dout_q, l_rw_q, l_wf_q;

    logic sel_mr, sel_mw, sel_fpu, sel_din, sel_dout, sel_rw, sel_wf;
    logic rx_mode, tx_mode, exec_done, pending, timeout, in_exec;

    // Decoder controls are only valid in the first EXEC cycle; afterwards the latched copies rule.
    always_comb begin
        sel_mr   = first_q ? mem_read  : l_mr_q;
        sel_mw   = first_q ? mem_write : l_mw_q;
        sel_fpu  = first_q ? use_fpu   : l_fpu_q;
        sel_din  = first_q ? data_in   : l_din_q;
        sel_dout = first_q ? data_out  : l_dout_q;
        sel_rw   = first_q ? reg_write : l_rw_q;
        sel_wf   = first_q ? writef    : l_wf_q;
        rx_mode  = ~sel_fpu & sel_din;
        tx_mode  = ~sel_fpu & ~sel_din & sel_dout;
        in_exec  = (state_q == S_EXEC);

        exec_done = 1'b1;
        if (sel_fpu)      exec_done = fpu_done & ~first_q;
        else if (rx_mode) exec_done = rx_valid;
        else if (tx_mode) exec_done = tx_ready;

        pending = 1'b0;
        case (state_q)
            S_FETCH: pending = imem_req_q & ~imem_ack;
            S_EXEC:  pending = ~exec_done;
            S_MEM:   pending = ~dmem_ack;
            default: pending = 1'b0;
        endcase

        timeout = pending & (wait_q == WAIT_W'(WAIT_MAX - 1));
        wait_d  = (pending & ~timeout) ? wait_q + WAIT_W'(1) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b0;
            ir_we_q    <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            pc_we_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            fpr_we_q   <= 1'b0;
            fault_q    <= 1'b0;
            first_q    <= 1'b0;
            retired_q  <= '0;
            wait_q     <= '0;
            {l_mr_q, l_mw_q, l_fpu_q, l_din_q, l_dout_q, l_rw_q, l_wf_q} <= '0;
        end else begin
            ir_we_q  <= 1'b0;
            pc_we_q  <= 1'b0;
            rf_we_q  <= 1'b0;
            fpr_we_q <= 1'b0;
            first_q  <= 1'b0;
            wait_q   <= wait_d;
            if (timeout) begin
                state_q    <= S_FAULT;
                fault_q    <= 1'b1;
                imem_req_q <= 1'b0;
                dmem_req_q <= 1'b0;
                dmem_we_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        if (!imem_req_q) begin
                            imem_req_q <= 1'b1;
                        end else if (imem_ack) begin
                            imem_req_q <= 1'b0;
                            ir_we_q    <= 1'b1;
                            state_q    <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        state_q <= S_EXEC;
                        first_q <= 1'b1;
                    end
                    S_EXEC: begin
                        if (first_q) begin
                            {l_mr_q, l_mw_q, l_fpu_q, l_din_q, l_dout_q, l_rw_q, l_wf_q} <=
                                {mem_read, mem_write, use_fpu, data_in, data_out, reg_write, writef};
                        end
                        if (exec_done) begin
                            if (sel_mr | sel_mw) begin
                                state_q    <= S_MEM;
                                dmem_req_q <= 1'b1;
                                dmem_we_q  <= sel_mw;
                            end else begin
                                state_q  <= S_WRITE;
                                pc_we_q  <= 1'b1;
                                rf_we_q  <= sel_rw & ~sel_wf;
                                fpr_we_q <= sel_wf;
                            end
                        end
                    end
                    S_MEM: begin
                        if (dmem_ack) begin
                            dmem_req_q <= 1'b0;
                            dmem_we_q  <= 1'b0;
                            state_q    <= S_WRITE;
                            pc_we_q    <= 1'b1;
                            rf_we_q    <= l_rw_q & ~l_wf_q;
                            fpr_we_q   <= l_wf_q;
                        end
                    end
                    S_WRITE: begin
                        retired_q  <= retired_q + CNT_W'(1);
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // EXEC-phase handshake strobes are decoded from state and the selected flags, so
    // fpu_start/rx_ready/tx_valid line up with the cycle the decoder controls are valid.
    assign fpu_start = in_exec & first_q & sel_fpu;
    assign rx_ready  = in_exec & rx_mode & rx_valid;
    assign tx_valid  = in_exec & tx_mode;

    assign state    = state_q;
    assign imem_req = imem_req_q;
    assign ir_we    = ir_we_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign pc_we    = pc_we_q;
    assign rf_we    = rf_we_q;
    assign fpr_we   = fpr_we_q;
    assign retired  = retired_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-instruction expected traces built from the
// sequencing rules, directed cases followed by randomized instructions, timeout and async reset.
module tb_core_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic imem_ack, dmem_ack, fpu_done, rx_valid, tx_ready;
    logic mem_read, mem_write, use_fpu, data_in, data_out, reg_write, writef;

    logic [2:0]  state_m, state_f;
    logic        imem_req_m, ir_we_m, dmem_req_m, dmem_we_m, fpu_start_m, rx_ready_m, tx_valid_m;
    logic        pc_we_m, rf_we_m, fpr_we_m, fault_m;
    logic        imem_req_f, ir_we_f, dmem_req_f, dmem_we_f, fpu_start_f, rx_ready_f, tx_valid_f;
    logic        pc_we_f, rf_we_f, fpr_we_f, fault_f;
    logic [31:0] retired_m, retired_f;
    logic [14:0] obs_m, obs_f;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cnt = '0;

    always #5 clk = ~clk;

    core_sequencer #(.CNT_W(32), .WAIT_MAX(64)) dut (
        .clk(clk), .rst(rst),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .fpu_done(fpu_done),
        .rx_valid(rx_valid), .tx_ready(tx_ready),
        .mem_read(mem_read), .mem_write(mem_write), .use_fpu(use_fpu),
        .data_in(data_in), .data_out(data_out), .reg_write(reg_write), .writef(writef),
        .state(state_m), .imem_req(imem_req_m), .ir_we(ir_we_m), .dmem_req(dmem_req_m),
        .dmem_we(dmem_we_m), .fpu_start(fpu_start_m), .rx_ready(rx_ready_m),
        .tx_valid(tx_valid_m), .pc_we(pc_we_m), .rf_we(rf_we_m), .fpr_we(fpr_we_m),
        .retired(retired_m), .fault(fault_m)
    );

    core_sequencer #(.CNT_W(32), .WAIT_MAX(8)) dut8 (
        .clk(clk), .rst(rst),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .fpu_done(fpu_done),
        .rx_valid(rx_valid), .tx_ready(tx_ready),
        .mem_read(mem_read), .mem_write(mem_write), .use_fpu(use_fpu),
        .data_in(data_in), .data_out(data_out), .reg_write(reg_write), .writef(writef),
        .state(state_f), .imem_req(imem_req_f), .ir_we(ir_we_f), .dmem_req(dmem_req_f),
        .dmem_we(dmem_we_f), .fpu_start(fpu_start_f), .rx_ready(rx_ready_f),
        .tx_valid(tx_valid_f), .pc_we(pc_we_f), .rf_we(rf_we_f), .fpr_we(fpr_we_f),
        .retired(retired_f), .fault(fault_f)
    );

    assign obs_m = {state_m, imem_req_m, ir_we_m, dmem_req_m, dmem_we_m, fpu_start_m,
                    rx_ready_m, tx_valid_m, pc_we_m, rf_we_m, fpr_we_m, fault_m};
    assign obs_f = {state_f, imem_req_f, ir_we_f, dmem_req_f, dmem_we_f, fpu_start_f,
                    rx_ready_f, tx_valid_f, pc_we_f, rf_we_f, fpr_we_f, fault_f};

    function automatic logic [14:0] mk(input logic [2:0] st, input logic ireq, input logic irwe,
                                       input logic dreq, input logic dwe, input logic fst,
                                       input logic rxr, input logic txv, input logic pcwe,
                                       input logic rfwe, input logic fprwe, input logic flt);
        return {st, ireq, irwe, dreq, dwe, fst, rxr, txv, pcwe, rfwe, fprwe, flt};
    endfunction

    task automatic cmp(input string tag, input int sel, input logic [14:0] exp, input logic [31:0] er);
        logic [14:0] o;
        logic [31:0] r;
        o = (sel == 1) ? obs_f : obs_m;
        r = (sel == 1) ? retired_f : retired_m;
        n_vec++;
        assert (o === exp) else begin
            n_err++;
            $error("FAIL %s ctl(dut%0d) got %b want %b", tag, sel, o, exp);
        end
        n_vec++;
        assert (r === er) else begin
            n_err++;
            $error("FAIL %s retired(dut%0d) got %0d want %0d", tag, sel, r, er);
        end
    endtask

    task automatic chk(input string tag, input int sel, input logic [14:0] exp, input logic [31:0] er);
        @(negedge clk);
        if (sel == 2) begin
            cmp(tag, 0, exp, er);
            cmp(tag, 1, exp, er);
        end else begin
            cmp(tag, sel, exp, er);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_noise();
        {imem_ack, dmem_ack, fpu_done, rx_valid, tx_ready} = 5'($urandom);
        {mem_read, mem_write, use_fpu, data_in, data_out, reg_write, writef} = 7'($urandom);
    endtask

    // Entered at posedge+1; asserts rst between edges and checks outputs clear without a clock.
    task automatic reset_seq();
        rst = 1'b1;
        #1;
        cmp("rst_async", 2 == 2 ? 0 : 0, mk(3'd0, 0,0,0,0,0,0,0,0,0,0,0), 32'd0);
        cmp("rst_async", 1, mk(3'd0, 0,0,0,0,0,0,0,0,0,0,0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = '0;
        set_noise();
        imem_ack = 1'b1;
        chk("idle_fetch", 2, mk(3'd0, 0,0,0,0,0,0,0,0,0,0,0), 32'd0);
    endtask

    // c = {mem_read, mem_write, use_fpu, data_in, data_out, reg_write, writef}
    task automatic instr(input string tag, input int sel, input int ia, input logic [6:0] c,
                         input int d, input int dm, input bit early, input int mem_abort);
        int m;
        int elen;
        int nmem;
        m    = c[4] ? 1 : c[3] ? 2 : c[2] ? 3 : 0;
        elen = (m == 0) ? 1 : d + 1;
        for (int k = 0; k <= ia; k++) begin
            set_noise();
            imem_ack = (k == ia);
            chk({tag, "_fetch"}, sel, mk(3'd0, 1,0,0,0,0,0,0,0,0,0,0), cnt);
        end
        set_noise();
        chk({tag, "_decode"}, sel, mk(3'd1, 0,1,0,0,0,0,0,0,0,0,0), cnt);
        for (int k = 0; k < elen; k++) begin
            set_noise();
            if (k == 0)
                {mem_read, mem_write, use_fpu, data_in, data_out, reg_write, writef} = c;
            if (m == 1) fpu_done = (k == d) || (k == 0 && early);
            if (m == 2) rx_valid = (k == d);
            if (m == 3) tx_ready = (k == d);
            chk({tag, "_exec"}, sel,
                mk(3'd2, 0,0,0,0, (m == 1 && k == 0), (m == 2 && k == d), (m == 3), 0,0,0,0), cnt);
        end
        if (c[6] | c[5]) begin
            nmem = (mem_abort > 0) ? mem_abort : dm + 1;
            for (int k = 0; k < nmem; k++) begin
                set_noise();
                dmem_ack = (mem_abort == 0) && (k == dm);
                chk({tag, "_mem"}, sel, mk(3'd3, 0,0,1,c[5],0,0,0,0,0,0,0), cnt);
            end
            if (mem_abort > 0) return;
        end
        set_noise();
        chk({tag, "_write"}, sel, mk(3'd4, 0,0,0,0,0,0,0,1, c[1] & ~c[0], c[0], 0), cnt);
        cnt = cnt + 32'd1;
    endtask

    initial begin
        logic [6:0] c;
        int         d;
        rst = 1'b1;
        {imem_ack, dmem_ack, fpu_done, rx_valid, tx_ready} = '0;
        {mem_read, mem_write, use_fpu, data_in, data_out, reg_write, writef} = '0;
        #1;
        reset_seq();

        instr("addi", 0, 2, 7'b0000010, 0, 0, 1'b0, 0);
        for (int i = 0; i < 5; i++) instr("lw", 0, 1, 7'b1000010, 0, 3, 1'b0, 0);
        instr("fadd", 0, 1, 7'b0010001, 7, 0, 1'b1, 0);
        instr("out", 0, 0, 7'b0000100, 10, 0, 1'b0, 0);
        instr("in", 0, 0, 7'b0001010, 0, 0, 1'b0, 0);
        instr("sw", 0, 0, 7'b0100000, 0, 2, 1'b0, 0);
        instr("prio", 0, 0, 7'b0011110, 3, 0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            c = 7'($urandom);
            d = c[4] ? int'($urandom_range(1, 10)) : int'($urandom_range(0, 10));
            instr("rnd", 0, int'($urandom_range(0, 4)), c, d, int'($urandom_range(0, 6)),
                  1'($urandom), 0);
        end

        instr("lw_abort", 0, 0, 7'b1000010, 0, 0, 1'b0, 2);
        set_noise();
        dmem_ack = 1'b0;
        #1;
        reset_seq();
        instr("restart", 2, 1, 7'b0000010, 0, 0, 1'b0, 0);

        reset_seq();
        for (int i = 0; i < 2; i++) begin
            c = 7'($urandom);
            d = c[4] ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 5));
            instr("pre_flt", 1, int'($urandom_range(0, 2)), c, d, int'($urandom_range(0, 3)),
                  1'($urandom), 0);
        end
        instr("flt", 1, 0, 7'b1000010, 0, 0, 1'b0, 8);
        for (int i = 0; i < 5; i++) begin
            set_noise();
            chk("fault_hold", 1, mk(3'd5, 0,0,0,0,0,0,0,0,0,0,1), cnt);
        end
        reset_seq();
        instr("post_flt", 2, 0, 7'b0000010, 0, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
